harness_driver: RTL

- Host-side sequencer for the byte-serial test harness: takes a full operand word, writes it byte-by-byte into the harness input register (data on ui_in, byte select on uio_in[LOG2_BYTES_IN-1:0]), waits for the harness output register to update, then sweeps the output byte select (uio_in[4+LOG2_BYTES_OUT-1:4]) and reassembles the result word from uo_out.
- Sits in the FPGA/bench wrapper in front of harness DUTs, so operand-in / result-out is a single valid/ready transaction.

---
 rtl/harness_driver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/harness_driver.sv
`default_nettype none
// ============================================================================
//  Module      : harness_driver
//  Description : Host-side sequencer for the byte-serial test harness.
//                Accepts one operand word, writes it byte by byte into the
//                harness input register, waits for the harness to settle,
//                sweeps the output byte select and reassembles the result.
//  Revision    : 1.0  initial release
// ============================================================================
module harness_driver #(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_valid,
    output logic                             start_ready,
    input  logic [(8<<LOG2_BYTES_IN)-1:0]    operand,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [(8<<LOG2_BYTES_OUT)-1:0]   result,
    output logic                             busy,
    output logic [7:0]                       drv_data,
    output logic [7:0]                       drv_sel,
    input  logic [7:0]                       dut_data
);

    localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
    localparam int BYTES_OUT = 1 << LOG2_BYTES_OUT;
    localparam int OP_W      = 8 * BYTES_IN;
    localparam int RES_W     = 8 * BYTES_OUT;
    // Settle counter only has to reach SETTLE_CYCLES-1; keep at least 1 bit.
    localparam int SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [LOG2_BYTES_IN-1:0]  WR_LAST     = LOG2_BYTES_IN'(BYTES_IN - 1);
    localparam logic [LOG2_BYTES_IN-1:0]  WR_ONE      = LOG2_BYTES_IN'(1);
    localparam logic [LOG2_BYTES_OUT-1:0] RD_LAST     = LOG2_BYTES_OUT'(BYTES_OUT - 1);
    localparam logic [LOG2_BYTES_OUT-1:0] RD_ONE      = LOG2_BYTES_OUT'(1);
    localparam logic [SET_W-1:0]          SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0]          SET_ONE     = SET_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_READ   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    state_q,    state_d;
    logic [OP_W-1:0]           operand_q,  operand_d;
    logic [7:0]                drv_data_q, drv_data_d;
    logic [LOG2_BYTES_IN-1:0]  wr_idx_q,   wr_idx_d;
    logic [LOG2_BYTES_OUT-1:0] rd_idx_q,   rd_idx_d;
    logic [SET_W-1:0]          settle_q,   settle_d;
    logic [RES_W-1:0]          result_q,   result_d;

    // Next write/read byte indices; only used when not on the last index,
    // so the natural wrap of the narrow counters is never observed.
    logic [LOG2_BYTES_IN-1:0]  w_wr_next;
    logic [LOG2_BYTES_OUT-1:0] w_rd_next;

    assign w_wr_next = wr_idx_q + WR_ONE;
    assign w_rd_next = rd_idx_q + RD_ONE;

    // State and datapath registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            operand_q  <= '0;
            drv_data_q <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            settle_q   <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            operand_q  <= operand_d;
            drv_data_q <= drv_data_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            settle_q   <= settle_d;
            result_q   <= result_d;
        end
    end

    // Sequencer: next-state, counters, byte write/read and handshake flags.
    always_comb begin
        state_d      = state_q;
        operand_d    = operand_q;
        drv_data_d   = drv_data_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        settle_d     = settle_q;
        result_d     = result_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;

        case (state_q)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    // Byte 0 goes out on the acceptance edge so the first
                    // LOAD cycle already presents it to the harness.
                    operand_d  = operand;
                    drv_data_d = operand[7:0];
                    wr_idx_d   = '0;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                if (wr_idx_q == WR_LAST) begin
                    // Last byte stays on the bus: the harness keeps rewriting
                    // the selected byte every clock, which is then harmless.
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end else begin
                    wr_idx_d   = w_wr_next;
                    drv_data_d = operand_q[{w_wr_next, 3'b000} +: 8];
                end
            end

            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    rd_idx_d = '0;
                    state_d  = S_READ;
                end else begin
                    settle_d = settle_q + SET_ONE;
                end
            end

            S_READ: begin
                // Harness output mux is combinational from the select, so the
                // byte for the current read index is valid within this cycle.
                result_d[{rd_idx_q, 3'b000} +: 8] = dut_data;
                if (rd_idx_q == RD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    rd_idx_d = w_rd_next;
                end
            end

            S_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Select bus: write index in the low field, read index from bit 4 up.
    always_comb begin
        drv_sel                         = '0;
        drv_sel[LOG2_BYTES_IN-1:0]      = wr_idx_q;
        drv_sel[4 +: LOG2_BYTES_OUT]    = rd_idx_q;
    end

    assign drv_data = drv_data_q;
    assign result   = result_q;

endmodule
`default_nettype wire
